// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: binary-to-BCD converter feeding a multiplexed 7-segment display.
// A load starts an iterative shift-add-3 conversion (one bit per cycle, MSB first),
// or jumps straight to "Err". The result is formatted into a frame buffer with
// leading-zero blanking, an optional minus sign and overflow detection. A prescaled
// scanner walks the digits and drives a registered one-hot select plus segment code.
module seg_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int DATA_W   = 8,
    parameter int PRESCALE = 1000
) (
    input  logic              i_sys_clock,
    input  logic              i_sys_reset,
    input  logic              i_seg_load,
    input  logic [DATA_W-1:0] i_seg_value,
    input  logic              i_seg_neg,
    input  logic              i_seg_err,
    input  logic              i_seg_enable,
    output logic              o_seg_busy,
    output logic              o_seg_done,
    output logic              o_seg_ovf,
    output logic [DIGITS-1:0] o_seg_sel,
    output logic [6:0]        o_seg_code
);

    localparam int NB    = (DATA_W + 3) / 3;  // ceil((DATA_W+1)/3) BCD digits
    localparam int BCD_W = 4 * NB;
    localparam int CNT_W = $clog2(DATA_W);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_R     = 7'h50;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_ZERO  = 7'h3F;

    typedef logic [DIGITS-1:0][6:0] frame_t;
    typedef enum logic {ST_IDLE, ST_CONV} state_t;

    function automatic logic [6:0] f_seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic frame_t f_err_frame();
        frame_t f;
        f    = '0;
        f[2] = SEG_E;
        f[1] = SEG_R;
        f[0] = SEG_R;
        return f;
    endfunction

    function automatic frame_t f_zero_frame();
        frame_t f;
        f    = '0;
        f[0] = SEG_ZERO;
        return f;
    endfunction

    state_t              r_state;
    state_t              w_state_next;
    logic                w_accept;
    logic                w_last;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_bin;
    logic [BCD_W-1:0]    r_bcd;
    logic [BCD_W-1:0]    w_bcd_adj;
    logic [BCD_W-1:0]    w_bcd_next;
    logic                r_neg;
    logic                r_done;
    logic                r_ovf;
    frame_t              r_frame;
    frame_t              w_conv_frame;
    logic                w_conv_ovf;
    int                  w_msd;
    int                  w_need;
    logic                w_nonzero;
    logic [PRE_W-1:0]    r_pre;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_next;
    logic                w_pre_tc;
    logic [DIGITS-1:0]   r_sel;
    logic [6:0]          r_code;

    // FSM state register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_sys_clock or negedge i_sys_reset) begin
        if (!i_sys_reset) r_state <= ST_IDLE;
        else              r_state <= w_state_next;
    end

    // FSM next-state: a non-error load starts DATA_W conversion cycles
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_accept     = i_seg_load && (r_state == ST_IDLE);
        w_last       = (r_state == ST_CONV) && (r_cnt == CNT_W'(DATA_W - 1));
        case (r_state)
            ST_IDLE: if (w_accept && !i_seg_err) w_state_next = ST_CONV;
            ST_CONV: if (w_last)                 w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Shift-add-3 step: correct each BCD digit >= 5, then shift in the next binary MSB
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < NB; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
        w_bcd_next = (w_bcd_adj << 1) | BCD_W'(r_bin[DATA_W-1]);
    end

    // Format the final BCD value: blank leading zeros, place sign, detect overflow
    always_comb begin
        w_msd     = 0;
        w_nonzero = |w_bcd_next;
        for (int k = 0; k < NB; k++) begin
            if (w_bcd_next[4*k +: 4] != 4'd0) w_msd = k;
        end
        w_need     = w_msd + 1 + ((r_neg && w_nonzero) ? 1 : 0);
        w_conv_ovf = (w_need > DIGITS);
        w_conv_frame = '0;
        for (int i = 0; i < DIGITS; i++) begin
            // Shifting (rather than part-selecting) keeps positions past NB in range.
            if (i <= w_msd)
                w_conv_frame[i] = f_seg_digit(4'(w_bcd_next >> (4 * i)));
            else if ((i == w_msd + 1) && r_neg && w_nonzero)
                w_conv_frame[i] = SEG_MINUS;
        end
        if (w_conv_ovf) w_conv_frame = f_err_frame();
    end

    // Conversion datapath and atomic frame-buffer update
    always_ff @(posedge i_sys_clock or negedge i_sys_reset) begin
        if (!i_sys_reset) begin
            r_cnt   <= '0;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_neg   <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            // NOTE: the frame buffer is a register bank, not RAM, so it is reset to a defined "0".
            r_frame <= f_zero_frame();
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_bin <= i_seg_value;
                r_bcd <= '0;
                r_cnt <= '0;
                r_neg <= i_seg_neg;
                if (i_seg_err) begin
                    r_frame <= f_err_frame();
                    r_ovf   <= 1'b1;
                    r_done  <= 1'b1;
                end
            end else if (r_state == ST_CONV) begin
                r_bin <= r_bin << 1;
                r_bcd <= w_bcd_next;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_frame <= w_conv_frame;
                    r_ovf   <= w_conv_ovf;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    // Scan timing: prescaler terminal count advances the digit index
    always_comb begin
        w_pre_tc   = (r_pre == PRE_W'(PRESCALE - 1));
        w_idx_next = r_idx;
        if (w_pre_tc) w_idx_next = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end

    // Prescaler and digit index registers
    always_ff @(posedge i_sys_clock or negedge i_sys_reset) begin
        if (!i_sys_reset) begin
            r_pre <= '0;
            r_idx <= '0;
        end else begin
            r_pre <= w_pre_tc ? '0 : r_pre + PRE_W'(1);
            r_idx <= w_idx_next;
        end
    end

    // Registered display outputs; select and code move together on the index edge
    always_ff @(posedge i_sys_clock or negedge i_sys_reset) begin
        if (!i_sys_reset) begin
            r_sel  <= DIGITS'(1);
            r_code <= SEG_ZERO;
        end else if (i_seg_enable) begin
            r_sel  <= DIGITS'(1) << w_idx_next;
            r_code <= r_frame[w_idx_next];
        end else begin
            r_sel  <= '0;
            r_code <= SEG_BLANK;
        end
    end

    assign o_seg_busy = (r_state == ST_CONV);
    assign o_seg_done = r_done;
    assign o_seg_ovf  = r_ovf;
    assign o_seg_sel  = r_sel;
    assign o_seg_code = r_code;

endmodule
